// File: rtl/turn_sequencer.sv
// Round controller for the chicken-chase game: judges each card flip, moves chicks,
// requests the next turn on a miss, verifies the turn changed, and detects the winner.
module turn_sequencer #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int WIN_STEPS   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] N,
  input  logic [1:0] turn_in,
  input  logic       flip,
  input  logic       match,
  output logic       statecombo_next_turn,
  output logic [2:0] state,
  output logic [3:0] pos0,
  output logic [3:0] pos1,
  output logic [3:0] pos2,
  output logic [3:0] pos3,
  output logic [1:0] winner,
  output logic       game_over,
  output logic       turn_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_FLIP = 3'd1,
    S_JUDGE     = 3'd2,
    S_SHOW      = 3'd3,
    S_ADVANCE   = 3'd4,
    S_SETTLE    = 3'd5,
    S_OVER      = 3'd6
  } state_t;

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          m_q;
  logic [1:0]    t_q;
  logic [3:0]    pos_q [4];
  logic [1:0]    winner_q;
  logic          game_over_q;
  logic          turn_err_q;
  logic          next_turn_q;

  logic [2:0]    player_cnt_d;
  logic [3:0]    active_d;
  logic          start_ok_d;

  assign player_cnt_d = {1'b0, N} + 3'd2;
  assign start_ok_d   = start && (N != 2'b11) &&
                        ((state_q == S_IDLE) || (state_q == S_OVER));

  // Players beyond the current player count never move.
  for (genvar gi = 0; gi < 4; gi++) begin : g_active
    assign active_d[gi] = (3'(gi) < player_cnt_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      m_q         <= 1'b0;
      t_q         <= 2'd0;
      winner_q    <= 2'd0;
      game_over_q <= 1'b0;
      turn_err_q  <= 1'b0;
      next_turn_q <= 1'b0;
      for (int i = 0; i < 4; i++) pos_q[i] <= 4'd0;
    end else begin
      next_turn_q <= 1'b0;
      if (start_ok_d) begin
        state_q     <= S_WAIT_FLIP;
        winner_q    <= 2'd0;
        game_over_q <= 1'b0;
        turn_err_q  <= 1'b0;
        for (int i = 0; i < 4; i++) pos_q[i] <= 4'd0;
      end else begin
        case (state_q)
          S_WAIT_FLIP: begin
            if (flip) begin
              m_q     <= match;
              t_q     <= turn_in;
              state_q <= S_JUDGE;
            end
          end
          S_JUDGE: begin
            if (m_q && active_d[t_q] && (pos_q[t_q] != 4'hF))
              pos_q[t_q] <= pos_q[t_q] + 4'd1;
            cnt_q   <= CW'(HOLD_CYCLES - 1);
            state_q <= S_SHOW;
          end
          S_SHOW: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else if (!m_q) begin
              next_turn_q <= 1'b1;
              state_q     <= S_ADVANCE;
            end else if (pos_q[t_q] >= 4'(WIN_STEPS)) begin
              winner_q    <= t_q;
              game_over_q <= 1'b1;
              state_q     <= S_OVER;
            end else begin
              state_q <= S_WAIT_FLIP;
            end
          end
          S_ADVANCE: state_q <= S_SETTLE;
          S_SETTLE: begin
            // The turn-advance block had one full cycle to react to the request.
            if (turn_in == t_q) turn_err_q <= 1'b1;
            state_q <= S_WAIT_FLIP;
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign statecombo_next_turn = next_turn_q;
  assign state                = state_q;
  assign pos0                 = pos_q[0];
  assign pos1                 = pos_q[1];
  assign pos2                 = pos_q[2];
  assign pos3                 = pos_q[3];
  assign winner               = winner_q;
  assign game_over            = game_over_q;
  assign turn_err             = turn_err_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: directed rounds plus a scoreboard of
// expected next-turn request cycles, with a small turn-advance model.
module tb_turn_sequencer;

  localparam int HOLD = 4;
  localparam int WIN  = 2;

  logic       clk = 1'b0;
  logic       rst, start, flip, match;
  logic [1:0] N, turn_in;
  logic       statecombo_next_turn, game_over, turn_err;
  logic [2:0] state;
  logic [3:0] pos0, pos1, pos2, pos3;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];
  logic prev_pulse = 1'b0;

  // Turn-advance model controls
  logic       load_req = 1'b0;
  logic [1:0] load_val = 2'd0;
  logic       freeze   = 1'b0;

  turn_sequencer #(.HOLD_CYCLES(HOLD), .WIN_STEPS(WIN)) dut (
    .clk(clk), .rst(rst), .start(start), .N(N), .turn_in(turn_in),
    .flip(flip), .match(match), .statecombo_next_turn(statecombo_next_turn),
    .state(state), .pos0(pos0), .pos1(pos1), .pos2(pos2), .pos3(pos3),
    .winner(winner), .game_over(game_over), .turn_err(turn_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_req)
      turn_in <= load_val;
    else if (statecombo_next_turn && !freeze)
      turn_in <= 2'((32'(turn_in) + 1) % (32'(N) + 2));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: every observed request must match the next expected cycle.
  always @(negedge clk) begin
    if (statecombo_next_turn) begin
      if (exp_q.size() == 0) check("unexpected_pulse", 1, 0);
      else check("pulse_cycle", cyc, exp_q.pop_front());
      if (prev_pulse) check("back_to_back", 1, 0);
      $display("request pulse observed at cycle %0d", cyc);
    end
    prev_pulse = statecombo_next_turn;
  end

  task automatic pulse_start(input logic [1:0] n);
    @(negedge clk); N = n; start = 1'b1;
    @(negedge clk); start = 1'b0;
    $display("start N=%0d -> state=%0d", n, state);
  endtask

  task automatic set_turn(input logic [1:0] v, input logic frz);
    @(negedge clk); load_val = v; load_req = 1'b1; freeze = frz;
    @(negedge clk); load_req = 1'b0;
  endtask

  // Returns the negedge cycle at which flip was raised; flip edge is t0+1.
  task automatic do_flip(input logic m, input logic expect_pulse, output int t0);
    @(negedge clk);
    t0 = cyc; flip = 1'b1; match = m;
    if (expect_pulse) exp_q.push_back(t0 + HOLD + 2);
    $display("flip match=%0d turn=%0d cycle=%0d", m, turn_in, t0);
    @(negedge clk); flip = 1'b0; match = 1'b0;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_req"}, statecombo_next_turn, 0);
    check({tag, "_pos"}, {pos3, pos2, pos1, pos0}, 0);
    check({tag, "_winner"}, winner, 0);
    check({tag, "_over"}, game_over, 0);
    check({tag, "_err"}, turn_err, 0);
  endtask

  int t0;

  initial begin
    rst = 1'b1; start = 1'b0; flip = 1'b0; match = 1'b0; N = 2'b01; turn_in = 2'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Start a 3-player game
    pulse_start(2'b01);
    check("start_state", state, 1);
    check("start_pos", {pos3, pos2, pos1, pos0}, 0);
    check("start_req", statecombo_next_turn, 0);

    // Miss by player 0; model advances turn to 1
    set_turn(2'd0, 1'b0);
    do_flip(1'b0, 1'b1, t0);
    wait_to(t0 + HOLD + 1);
    check("miss_still_show", state, 3);
    wait_to(t0 + HOLD + 2);
    check("miss_advance", state, 4);
    wait_to(t0 + HOLD + 4);
    check("miss_state", state, 1);
    check("miss_err", turn_err, 0);
    check("miss_turn", turn_in, 1);
    check("miss_pos", {pos3, pos2, pos1, pos0}, 0);

    // Match by player 2 in a 4-player game
    N = 2'b10;
    set_turn(2'd2, 1'b0);
    do_flip(1'b1, 1'b0, t0);
    wait_to(t0 + 2);
    check("hit_show", state, 3);
    check("hit_pos2", pos2, 1);
    wait_to(t0 + HOLD + 1);
    check("hit_still_show", state, 3);
    wait_to(t0 + HOLD + 2);
    check("hit_back", state, 1);

    // Player 1 wins with two matches
    set_turn(2'd1, 1'b0);
    do_flip(1'b1, 1'b0, t0);
    wait_to(t0 + HOLD + 2);
    check("win1_state", state, 1);
    check("win1_pos1", pos1, 1);
    do_flip(1'b1, 1'b0, t0);
    wait_to(t0 + HOLD + 2);
    check("win_state", state, 6);
    check("win_over", game_over, 1);
    check("win_winner", winner, 1);
    check("win_pos", {pos3, pos2, pos1, pos0}, {4'd0, 4'd1, 4'd2, 4'd0});
    do_flip(1'b1, 1'b0, t0);
    wait_to(t0 + 4);
    check("over_flip_state", state, 6);
    check("over_flip_pos1", pos1, 2);
    pulse_start(2'b10);
    check("restart_state", state, 1);
    check("restart_pos", {pos3, pos2, pos1, pos0}, 0);
    check("restart_over", game_over, 0);

    // Turn value stuck -> sticky turn_err
    set_turn(2'd0, 1'b1);
    do_flip(1'b0, 1'b1, t0);
    wait_to(t0 + HOLD + 4);
    check("stuck_state", state, 1);
    check("stuck_err", turn_err, 1);
    do_flip(1'b1, 1'b0, t0);
    wait_to(t0 + HOLD + 2);
    check("stuck_persist", turn_err, 1);
    check("stuck_pos0", pos0, 1);

    // Reset during SHOW
    do_flip(1'b1, 1'b0, t0);
    wait_to(t0 + 3);
    check("rst_show_pre", state, 3);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_show");
    rst = 1'b0;

    // Reset during ADVANCE drops the request
    pulse_start(2'b01);
    set_turn(2'd0, 1'b0);
    do_flip(1'b0, 1'b1, t0);
    wait_to(t0 + HOLD + 2);
    check("rst_adv_pre", state, 4);
    check("rst_adv_req", statecombo_next_turn, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_adv");
    rst = 1'b0;

    // Invalid player count is ignored
    pulse_start(2'b11);
    check("invalid_n_state", state, 0);
    repeat (2) @(negedge clk);
    check("invalid_n_hold", state, 0);

    check("pending_pulses", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
